// File: rtl/fp_norm_pack_seq.sv
// Post-add normalise and pack stage for the single-precision FPU.
// One shift per clock, truncating, one operation in flight.
module fp_norm_pack_seq #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     sign_in,
  input  logic [EXP_W-1:0]         exp_in,
  input  logic [MANT_W-1:0]        mant_in,
  input  logic                     cout_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MANT_W-1:0]  result,
  output logic                     zero,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int RES_W = EXP_W + MANT_W;
  localparam int FRC_W = MANT_W - 1;

  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic [EXP_W-1:0] EXP_ONE =
    {{(EXP_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic                sign_q, sign_d;
  logic [EXP_W-1:0]    exp_q, exp_d;
  logic [MANT_W-1:0]   mant_q, mant_d;
  logic                carry_q, carry_d;
  logic                vld_q, vld_d;
  logic [RES_W-1:0]    res_q, res_d;
  logic                zero_q, zero_d;
  logic                ovf_q, ovf_d;
  logic                udf_q, udf_d;
  logic [EXP_W-1:0]    exp_inc;
  logic [EXP_W-1:0]    exp_dec;

  assign exp_inc = exp_q + EXP_ONE;
  assign exp_dec = exp_q - EXP_ONE;

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    mant_d  = mant_q;
    carry_d = carry_q;
    vld_d   = vld_q;
    res_d   = res_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = sign_in;
          exp_d   = exp_in;
          mant_d  = mant_in;
          carry_d = cout_in;
          state_d = NORM;
        end
      end
      NORM: begin
        if (carry_q) begin
          mant_d  = {1'b1, mant_q[MANT_W-1:1]};
          exp_d   = exp_inc;
          carry_d = 1'b0;
          if (exp_inc == EXP_MAX) begin
            mant_d  = '0;
            ovf_d   = 1'b1;
            vld_d   = 1'b1;
            res_d   = {sign_q, EXP_MAX,
                       {FRC_W{1'b0}}};
            state_d = DONE;
          end
        end else if (mant_q == '0) begin
          zero_d  = 1'b1;
          vld_d   = 1'b1;
          res_d   = '0;
          state_d = DONE;
        end else if (mant_q[MANT_W-1]) begin
          vld_d   = 1'b1;
          res_d   = {sign_q, exp_q,
                     mant_q[FRC_W-1:0]};
          state_d = DONE;
        end else if (exp_q == EXP_ONE) begin
          udf_d   = 1'b1;
          vld_d   = 1'b1;
          res_d   = {sign_q, {EXP_W{1'b0}},
                     mant_q[FRC_W-1:0]};
          state_d = DONE;
        end else begin
          mant_d = {mant_q[MANT_W-2:0], 1'b0};
          exp_d  = exp_dec;
        end
      end
      DONE: begin
        if (out_ready) begin
          vld_d   = 1'b0;
          zero_d  = 1'b0;
          ovf_d   = 1'b0;
          udf_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      mant_q  <= '0;
      carry_q <= 1'b0;
      vld_q   <= 1'b0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      mant_q  <= mant_d;
      carry_q <= carry_d;
      vld_q   <= vld_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  assign in_ready  = rst_n && (state_q == IDLE);
  assign out_valid = vld_q;
  assign result    = res_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;
  assign underflow = udf_q;

endmodule

// File: tb/tb_fp_norm_pack_seq.sv
// Directed bench for fp_norm_pack_seq.
// Hand-computed vectors, latency and flag checks.
module tb_fp_norm_pack_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        sign_in;
  logic [7:0]  exp_in;
  logic [23:0] mant_in;
  logic        cout_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        overflow;
  logic        underflow;

  int errors = 0;
  int checks = 0;

  fp_norm_pack_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sign_in   (sign_in),
    .exp_in    (exp_in),
    .mant_in   (mant_in),
    .cout_in   (cout_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic start_op(input logic s,
                          input logic [7:0] e,
                          input logic [23:0] m,
                          input logic c);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    sign_in  = s;
    exp_in   = e;
    mant_in  = m;
    cout_in  = c;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    sign_in  = ~s;
    exp_in   = 8'h55;
    mant_in  = 24'hAAAAAA;
    cout_in  = 1'b1;
  endtask

  task automatic run_op(input logic s,
                        input logic [7:0] e,
                        input logic [23:0] m,
                        input logic c,
                        output int lat,
                        output logic [31:0] r,
                        output logic [2:0] fl);
    start_op(s, e, m, c);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    r  = result;
    fl = {zero, overflow, underflow};
  endtask

  task automatic ack();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst.in_ready got=%b exp=0", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst.out_valid got=%b exp=0", out_valid);
    end
    checks++;
    if (result !== 32'h0) begin
      errors++;
      $display("FAIL rst.result got=%h exp=0", result);
    end
    checks++;
    if ({zero, overflow, underflow} !== 3'b000) begin
      errors++;
      $display("FAIL rst.flags got=%b exp=000",
               {zero, overflow, underflow});
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst.ready_after got=%b exp=1", in_ready);
    end
  endtask

  task automatic test_normal();
    int lat;
    logic [31:0] r;
    logic [2:0] fl;
    run_op(1'b0, 8'd127, 24'h800000, 1'b0, lat, r, fl);
    checks++;
    if (r !== 32'h3F800000) begin
      errors++;
      $display("FAIL one.result got=%h exp=3f800000", r);
    end
    checks++;
    if (fl !== 3'b000) begin
      errors++;
      $display("FAIL one.flags got=%b exp=000", fl);
    end
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL one.latency got=%0d exp=1", lat);
    end
    ack();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL one.ack vld=%b rdy=%b exp vld=0 rdy=1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_carry();
    int lat;
    logic [31:0] r;
    logic [2:0] fl;
    run_op(1'b0, 8'd127, 24'h000000, 1'b1, lat, r, fl);
    checks++;
    if (r !== 32'h40000000) begin
      errors++;
      $display("FAIL carry.result got=%h exp=40000000", r);
    end
    checks++;
    if (fl !== 3'b000) begin
      errors++;
      $display("FAIL carry.flags got=%b exp=000", fl);
    end
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL carry.latency got=%0d exp=2", lat);
    end
    ack();
  endtask

  task automatic test_max_shift();
    int lat;
    logic [31:0] r;
    logic [2:0] fl;
    run_op(1'b1, 8'd127, 24'h000001, 1'b0, lat, r, fl);
    checks++;
    if (r !== 32'hB4000000) begin
      errors++;
      $display("FAIL shift23.result got=%h exp=b4000000", r);
    end
    checks++;
    if (fl !== 3'b000) begin
      errors++;
      $display("FAIL shift23.flags got=%b exp=000", fl);
    end
    checks++;
    if (lat !== 24) begin
      errors++;
      $display("FAIL shift23.latency got=%0d exp=24", lat);
    end
    ack();
  endtask

  task automatic test_zero();
    int lat;
    logic [31:0] r;
    logic [2:0] fl;
    run_op(1'b1, 8'd100, 24'h000000, 1'b0, lat, r, fl);
    checks++;
    if (r !== 32'h00000000) begin
      errors++;
      $display("FAIL zero.result got=%h exp=00000000", r);
    end
    checks++;
    if (fl !== 3'b100) begin
      errors++;
      $display("FAIL zero.flags got=%b exp=100", fl);
    end
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL zero.latency got=%0d exp=1", lat);
    end
    ack();
  endtask

  task automatic test_overflow();
    int lat;
    logic [31:0] r;
    logic [2:0] fl;
    run_op(1'b0, 8'd254, 24'h000000, 1'b1, lat, r, fl);
    checks++;
    if (r !== 32'h7F800000) begin
      errors++;
      $display("FAIL ovf.result got=%h exp=7f800000", r);
    end
    checks++;
    if (fl !== 3'b010) begin
      errors++;
      $display("FAIL ovf.flags got=%b exp=010", fl);
    end
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL ovf.latency got=%0d exp=1", lat);
    end
    ack();
  endtask

  task automatic test_denormal();
    int lat;
    logic [31:0] r;
    logic [2:0] fl;
    run_op(1'b0, 8'd3, 24'h100000, 1'b0, lat, r, fl);
    checks++;
    if (r !== 32'h00400000) begin
      errors++;
      $display("FAIL denorm.result got=%h exp=00400000", r);
    end
    checks++;
    if (fl !== 3'b001) begin
      errors++;
      $display("FAIL denorm.flags got=%b exp=001", fl);
    end
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL denorm.latency got=%0d exp=3", lat);
    end
    ack();
  endtask

  task automatic test_hold();
    int lat;
    logic [31:0] r;
    logic [2:0] fl;
    run_op(1'b1, 8'd3, 24'h100000, 1'b0, lat, r, fl);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (result !== 32'h80400000 || underflow !== 1'b1
          || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold.%0d res=%h udf=%b vld=%b rdy=%b exp res=80400000 udf=1 vld=1 rdy=0",
                 i, result, underflow, out_valid, in_ready);
      end
    end
    ack();
    checks++;
    if ({zero, overflow, underflow} !== 3'b000
        || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold.clear flags=%b vld=%b exp 000/0",
               {zero, overflow, underflow}, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [31:0] r;
    logic [2:0] fl;
    run_op(1'b0, 8'd50, 24'h000000, 1'b0, lat, r, fl);
    checks++;
    if (fl !== 3'b100 || r !== 32'h0) begin
      errors++;
      $display("FAIL b2b.first res=%h fl=%b exp 0/100", r, fl);
    end
    ack();
    run_op(1'b1, 8'd130, 24'h400000, 1'b0, lat, r, fl);
    checks++;
    if (r !== 32'hC0800000) begin
      errors++;
      $display("FAIL b2b.result got=%h exp=c0800000", r);
    end
    checks++;
    if (fl !== 3'b000 || lat !== 2) begin
      errors++;
      $display("FAIL b2b.flags_lat fl=%b lat=%0d exp 000/2",
               fl, lat);
    end
    ack();
  endtask

  task automatic test_reset_mid();
    int seen;
    start_op(1'b0, 8'd127, 24'h000001, 1'b0);
    repeat (5) begin
      @(posedge clk); #1;
    end
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid.busy vld=%b rdy=%b exp 0/0",
               out_valid, in_ready);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0
        || result !== 32'h0
        || {zero, overflow, underflow} !== 3'b000) begin
      errors++;
      $display("FAIL mid.reset vld=%b rdy=%b res=%h fl=%b exp all 0",
               out_valid, in_ready, result,
               {zero, overflow, underflow});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL mid.no_output got=%0d valid cycles exp=0",
               seen);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid.idle got rdy=%b exp=1", in_ready);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sign_in   = 1'b0;
    exp_in    = '0;
    mant_in   = '0;
    cout_in   = 1'b0;
    test_reset();
    test_normal();
    test_carry();
    test_max_shift();
    test_zero();
    test_overflow();
    test_denormal();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
